// File: rtl/jpeg_dequant_zigzag.sv
// jpeg_dequant_zigzag
//   Dequantizer and zigzag-to-natural reorder stage ahead of the 1-D IDCT.
//   Coefficients arrive one per beat in zigzag order. Each one is multiplied
//   by its quantization entry and written to a ping-pong 8x8 block buffer in
//   row-major order. Full blocks are presented one row (eight values) per
//   handshake.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   q_wr_en/addr/data        quant table write; the address is the zigzag index
//   coef_in/valid/ready      coefficient stream in zigzag order
//   coef_eob                 end-of-block flag (only with JPEG_DQ_EOB_EN)
//   row_valid/ready          row handshake
//   row_idx, row_last        current row number, and row_idx==7
//   row0..row7               dequantized columns 0..7 of the current row
//
// Build option
//   JPEG_DQ_EOB_EN : adds coef_eob and a per-bank written mask. Positions
//                    that were not written read back as zero.
module jpeg_dequant_zigzag #(
  parameter int COEF_W = 16,
  parameter int Q_W    = 8,
  parameter int OUT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     q_wr_en,
  input  logic [5:0]               q_wr_addr,
  input  logic [Q_W-1:0]           q_wr_data,
  input  logic signed [COEF_W-1:0] coef_in,
  input  logic                     coef_valid,
`ifdef JPEG_DQ_EOB_EN
  input  logic                     coef_eob,
`endif
  output logic                     coef_ready,
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic [2:0]               row_idx,
  output logic                     row_last,
  output logic signed [OUT_W-1:0]  row0,
  output logic signed [OUT_W-1:0]  row1,
  output logic signed [OUT_W-1:0]  row2,
  output logic signed [OUT_W-1:0]  row3,
  output logic signed [OUT_W-1:0]  row4,
  output logic signed [OUT_W-1:0]  row5,
  output logic signed [OUT_W-1:0]  row6,
  output logic signed [OUT_W-1:0]  row7
);

  // A signed COEF_W value times an unsigned Q_W value always fits in COEF_W+Q_W bits.
  localparam int PROD_W = COEF_W + Q_W;

  // Zigzag index -> natural (row-major) position.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [5:0]               cnt_q, cnt_d;
  logic                     wr_bank_q, wr_bank_d;
  logic                     rd_bank_q, rd_bank_d;
  logic [1:0]               full_q, full_d;
  logic [2:0]               row_idx_q, row_idx_d;
  logic [Q_W-1:0]           q_tab_q [64];
  logic signed [PROD_W-1:0] buf_q [2][64];

  logic                     beat_acc;
  logic                     row_acc;
  logic                     eob;
  logic                     blk_done;
  logic [5:0]               zz_pos;
  logic signed [PROD_W-1:0] prod;

`ifdef JPEG_DQ_EOB_EN
  logic [63:0] mask_q [2];
  assign eob = coef_eob;
`else
  assign eob = 1'b0;
`endif

  // Handshakes come from registered bank state only; reset forces both low.
  assign coef_ready = !rst && !full_q[wr_bank_q];
  assign row_valid  = !rst && full_q[rd_bank_q];
  assign beat_acc   = coef_valid && coef_ready;
  assign row_acc    = row_valid && row_ready;
  assign blk_done   = beat_acc && ((cnt_q == 6'd63) || eob);
  assign zz_pos     = ZZ[cnt_q];
  // Zero-extend the table entry so it multiplies as a non-negative value.
  assign prod       = coef_in * $signed({1'b0, q_tab_q[cnt_q]});

  always_comb begin
    cnt_d     = cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    row_idx_d = row_idx_q;
    if (beat_acc) begin
      cnt_d = cnt_q + 6'd1;
      if (blk_done) begin
        cnt_d             = 6'd0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    // Filling and draining always target different banks, so both updates
    // can land in the same cycle.
    if (row_acc) begin
      if (row_idx_q == 3'd7) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        row_idx_d         = 3'd0;
      end else begin
        row_idx_d = row_idx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      row_idx_q <= '0;
      for (int i = 0; i < 64; i++) q_tab_q[i] <= Q_W'(1);
`ifdef JPEG_DQ_EOB_EN
      mask_q[0] <= '0;
      mask_q[1] <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      row_idx_q <= row_idx_d;
      // Beats read q_tab_q before this write lands, so a same-cycle beat
      // sees the old entry.
      if (q_wr_en) q_tab_q[q_wr_addr] <= q_wr_data;
`ifdef JPEG_DQ_EOB_EN
      if (beat_acc) mask_q[wr_bank_q][zz_pos] <= 1'b1;
      if (row_acc && row_idx_q == 3'd7) mask_q[rd_bank_q] <= '0;
`endif
    end
  end

  // Block storage carries no reset: a bank is only read once it is full.
  always_ff @(posedge clk) begin
    if (beat_acc) buf_q[wr_bank_q][zz_pos] <= prod;
  end

  logic signed [OUT_W-1:0] row_w [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_col
    logic [5:0]               pos;
    logic signed [PROD_W-1:0] val;
    assign pos = {row_idx_q, 3'(gi)};
    assign val = buf_q[rd_bank_q][pos];
`ifdef JPEG_DQ_EOB_EN
    assign row_w[gi] = mask_q[rd_bank_q][pos] ? {{(OUT_W-PROD_W){val[PROD_W-1]}}, val} : '0;
`else
    assign row_w[gi] = {{(OUT_W-PROD_W){val[PROD_W-1]}}, val};
`endif
  end

  assign row_idx  = row_idx_q;
  assign row_last = (row_idx_q == 3'd7);
  assign row0 = row_w[0];
  assign row1 = row_w[1];
  assign row2 = row_w[2];
  assign row3 = row_w[3];
  assign row4 = row_w[4];
  assign row5 = row_w[5];
  assign row6 = row_w[6];
  assign row7 = row_w[7];

endmodule

// File: tb/tb_jpeg_dequant_zigzag.sv
// Testbench for jpeg_dequant_zigzag: a scoreboard of expected rows is filled
// when blocks are driven and drained by a monitor on every row handshake.
module tb_jpeg_dequant_zigzag;
  localparam int COEF_W = 16;
  localparam int Q_W    = 8;
  localparam int OUT_W  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic                     q_wr_en;
  logic [5:0]               q_wr_addr;
  logic [Q_W-1:0]           q_wr_data;
  logic signed [COEF_W-1:0] coef_in;
  logic                     coef_valid;
  logic                     coef_ready;
  logic                     row_valid;
  logic                     row_ready;
  logic [2:0]               row_idx;
  logic                     row_last;
  logic signed [OUT_W-1:0]  row0, row1, row2, row3, row4, row5, row6, row7;
`ifdef JPEG_DQ_EOB_EN
  logic                     coef_eob = 1'b0;
`endif

  jpeg_dequant_zigzag #(.COEF_W(COEF_W), .Q_W(Q_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst),
    .q_wr_en(q_wr_en), .q_wr_addr(q_wr_addr), .q_wr_data(q_wr_data),
    .coef_in(coef_in), .coef_valid(coef_valid),
`ifdef JPEG_DQ_EOB_EN
    .coef_eob(coef_eob),
`endif
    .coef_ready(coef_ready),
    .row_valid(row_valid), .row_ready(row_ready),
    .row_idx(row_idx), .row_last(row_last),
    .row0(row0), .row1(row1), .row2(row2), .row3(row3),
    .row4(row4), .row5(row5), .row6(row6), .row7(row7)
  );

  logic signed [OUT_W-1:0] rows [8];
  assign rows[0] = row0;
  assign rows[1] = row1;
  assign rows[2] = row2;
  assign rows[3] = row3;
  assign rows[4] = row4;
  assign rows[5] = row5;
  assign rows[6] = row6;
  assign rows[7] = row7;

  typedef struct packed {
    logic [2:0]             idx;
    logic [8*OUT_W-1:0]     data;
  } exp_row_t;

  exp_row_t exp_q[$];
  int zz_m [64];
  int qm [64];
  int coefs_m [64];
  int nat_m [64];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Zigzag order generated by walking anti-diagonals.
  initial begin
    int r, c;
    r = 0; c = 0;
    for (int n = 0; n < 64; n++) begin
      zz_m[n] = r * 8 + c;
      if (((r + c) % 2) == 0) begin
        if (c == 7) r++;
        else if (r == 0) c++;
        else begin r--; c++; end
      end else begin
        if (r == 7) c++;
        else if (c == 0) r++;
        else begin r++; c--; end
      end
    end
  end

  task automatic push_rows();
    exp_row_t e;
    for (int r = 0; r < 8; r++) begin
      e.idx = 3'(r);
      for (int c = 0; c < 8; c++) e.data[c*OUT_W +: OUT_W] = OUT_W'(nat_m[r*8+c]);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_beat(input int c, input int wa, input int wv);
    int budget;
    budget = 0;
    coef_valid = 1'b1;
    coef_in = 16'(c);
    while (!coef_ready && budget < 1000) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!coef_ready) check("coef_ready_timeout", coef_ready, 1);
    else begin
      if (wa >= 0) begin
        q_wr_en = 1'b1; q_wr_addr = 6'(wa); q_wr_data = 8'(wv);
      end
      @(posedge clk); #1;
    end
    coef_valid = 1'b0;
    q_wr_en = 1'b0;
  endtask

  // Sends coefs_m as one block; optionally writes q[wa]=wv in the same cycle
  // that beat wa is accepted (that beat still uses the old entry).
  task automatic send_block(input int wa, input int wv);
    for (int p = 0; p < 64; p++) nat_m[p] = 0;
    for (int n = 0; n < 64; n++) nat_m[zz_m[n]] = coefs_m[n] * qm[n];
    push_rows();
    for (int n = 0; n < 64; n++) send_beat(coefs_m[n], (n == wa) ? n : -1, wv);
    if (wa >= 0) qm[wa] = wv;
  endtask

  task automatic write_q(input int a, input int d);
    q_wr_en = 1'b1; q_wr_addr = 6'(a); q_wr_data = 8'(d);
    @(posedge clk); #1;
    q_wr_en = 1'b0;
    qm[a] = d;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    row_ready = 1'b1;
    while (exp_q.size() != 0 && budget < 1000) begin
      @(posedge clk); #1;
      budget++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: compares accepted rows against the scoreboard and checks that
  // outputs hold across stalled cycles.
  initial begin
    logic stall_prev;
    logic [2:0] held_idx;
    logic signed [OUT_W-1:0] held [8];
    logic signed [OUT_W-1:0] ev;
    exp_row_t e;
    stall_prev = 1'b0;
    held_idx = '0;
    for (int c = 0; c < 8; c++) held[c] = '0;
    forever begin
      @(negedge clk);
      if (rst) stall_prev = 1'b0;
      else begin
        if (stall_prev) begin
          check("stall_row_valid", row_valid, 1);
          check("stall_row_idx", row_idx, held_idx);
          for (int c = 0; c < 8; c++) check($sformatf("stall_col%0d", c), rows[c], held[c]);
        end
        if (row_valid && row_ready) begin
          if (exp_q.size() == 0) check("unexpected_row", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("row_idx", row_idx, e.idx);
            check("row_last", row_last, (e.idx == 3'd7) ? 1 : 0);
            for (int c = 0; c < 8; c++) begin
              ev = e.data[c*OUT_W +: OUT_W];
              check($sformatf("r%0d_c%0d", e.idx, c), rows[c], ev);
            end
          end
        end
        stall_prev = row_valid && !row_ready;
        held_idx = row_idx;
        for (int c = 0; c < 8; c++) held[c] = rows[c];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int n = 0; n < 64; n++) qm[n] = 1;
    rst = 1'b1; q_wr_en = 1'b0; q_wr_addr = '0; q_wr_data = '0;
    coef_in = '0; coef_valid = 1'b0; row_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_coef_ready", coef_ready, 0);
    check("rst_row_valid", row_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("init_coef_ready", coef_ready, 1);
    check("init_row_valid", row_valid, 0);
    check("init_row_idx", row_idx, 0);
    check("init_row_last", row_last, 0);

    // Identity table, coef = zigzag index.
    row_ready = 1'b1;
    for (int n = 0; n < 64; n++) coefs_m[n] = n;
    send_block(-1, 0);
    drain();

    // DC-only block with q[0]=16.
    write_q(0, 16);
    for (int n = 0; n < 64; n++) coefs_m[n] = (n == 0) ? -3 : 0;
    send_block(-1, 0);
    drain();

    // Extreme products, plus a table write colliding with beat 5.
    write_q(0, 255);
    write_q(63, 255);
    for (int n = 0; n < 64; n++) coefs_m[n] = int'($urandom_range(0, 2000)) - 1000;
    coefs_m[0] = 32767;
    coefs_m[63] = -32768;
    send_block(5, 9);
    for (int n = 0; n < 64; n++) coefs_m[n] = n + 1;
    send_block(-1, 0);
    drain();

    // Back-pressure: two blocks fill both banks, then release row by row.
    row_ready = 1'b0;
    for (int n = 0; n < 64; n++) coefs_m[n] = n * 3 - 90;
    send_block(-1, 0);
    check("after64_coef_ready", coef_ready, 1);
    for (int n = 0; n < 64; n++) coefs_m[n] = 7 - n * 5;
    send_block(-1, 0);
    check("after128_coef_ready", coef_ready, 0);
    coef_valid = 1'b1;
    coef_in = 16'sd1234;
    repeat (4) begin
      @(posedge clk); #1;
      check("stalled_coef_ready", coef_ready, 0);
    end
    coef_valid = 1'b0;
    for (int r = 0; r < 8; r++) begin
      row_ready = 1'b1;
      check("pre_accept_coef_ready", coef_ready, 0);
      @(posedge clk); #1;
      row_ready = 1'b0;
      check("post_accept_coef_ready", coef_ready, (r == 7) ? 1 : 0);
      repeat (2) @(posedge clk);
      #1;
    end
    drain();

    // Reset in the middle of a block, then a fresh block.
    for (int n = 0; n < 30; n++) send_beat(500 + n, -1, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_coef_ready", coef_ready, 0);
    check("midrst_row_valid", row_valid, 0);
    rst = 1'b0;
    for (int n = 0; n < 64; n++) qm[n] = 1;
    @(posedge clk); #1;
    check("postrst_row_idx", row_idx, 0);
    check("postrst_row_valid", row_valid, 0);
    for (int n = 0; n < 64; n++) coefs_m[n] = int'($urandom_range(0, 60000)) - 30000;
    send_block(-1, 0);
    drain();

`ifdef JPEG_DQ_EOB_EN
    // Short block terminated by end-of-block on its third beat.
    for (int p = 0; p < 64; p++) nat_m[p] = 0;
    nat_m[0] = 5; nat_m[1] = 7; nat_m[8] = 9;
    push_rows();
    send_beat(5, -1, 0);
    send_beat(7, -1, 0);
    coef_eob = 1'b1;
    send_beat(9, -1, 0);
    coef_eob = 1'b0;
    drain();
    for (int n = 0; n < 64; n++) coefs_m[n] = 2 * n - 40;
    send_block(-1, 0);
    drain();
`endif

    check("end_row_valid", row_valid, 0);
    check("end_coef_ready", coef_ready, 1);
    check("end_scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jpeg_dequant_zigzag.md
Name: jpeg_dequant_zigzag

Overview:
Upstream neighbour of the 1-D IDCT. Accepts one quantized DCT coefficient per cycle in zigzag order. Multiplies each by its quantization-table entry and writes it to an 8x8 block buffer in natural (row-major) order. Presents completed blocks row by row as eight 32-bit signed values that feed the IDCT in0..in7 directly; the buffer is ping-pong double-buffered so the next block can be loaded while the previous one is read out.

Parameters:
COEF_W, 16, signed coefficient input width
Q_W, 8, unsigned quantization table entry width
OUT_W, 32, signed row output width (matches IDCT input width)

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous active-high reset
q_wr_en  input  1  quant table write strobe
q_wr_addr  input  6  table address, zigzag index
q_wr_data  input  Q_W  table entry
coef_in  input  COEF_W  signed coefficient, zigzag order
coef_valid  input  1  coefficient beat valid
coef_ready  output  1  block can accept a beat
row_valid  output  1  row0..row7 hold a valid row
row_ready  input  1  consumer accepts the row
row_idx  output  3  row number 0..7 of the current row
row_last  output  1  high when row_idx==7
row0..row7  output  OUT_W each  dequantized row, column 0..7

Behaviour:
- Reset: coefficient count=0, write bank=0, read bank=0, both banks empty, row_idx=0, quant table all entries=1. During reset coef_ready=0 and row_valid=0; coef_ready=1 the cycle after reset deasserts.
- Reset mid-operation discards any partial or full block; it is never output.
- Quant table: a write takes effect the following cycle. A beat accepted in the same cycle as a write to its address uses the old value.
- Input handshake: a beat is accepted when coef_valid && coef_ready. Beat n (n=0..63 within the block) uses q[n] and is stored at natural position zz(n), the standard JPEG zigzag map (0->0, 1->1, 2->8, 3->16, 4->9, 5->2, ... 63->63).
- Arithmetic: product = coef_in (signed) * q (zero-extended, unsigned) = 24-bit signed, sign-extended to OUT_W. No rounding or saturation.
- Block completion: the 64th accepted beat marks the write bank full and toggles the write bank; the count wraps to 0.
- coef_ready = !full[write bank], from registered state only. It has no combinational dependency on coef_valid or row_ready.
- Output side: row_valid = full[read bank], asserted the cycle after the edge that accepted the 64th beat. row0..row7 = buffer[read bank][row_idx*8 + 0..7].
- Row handshake: on row_valid && row_ready, row_idx increments. Acceptance with row_idx==7 marks the read bank empty, toggles the read bank and sets row_idx=0.
- While row_valid && !row_ready, all row outputs, row_idx and row_last hold stable.
- Simultaneous events:
  - The 64th write on one bank and the row-7 accept on the other bank in the same cycle both take effect.
  - A bank freed by a row-7 accept raises coef_ready on the next cycle, not the same cycle.
- Throughput: 64 input cycles per block and 8 output cycles per block; no bubbles when both sides run continuously.

Optional Feature:
JPEG_DQ_EOB_EN
- Defined: adds input port coef_eob (1 bit), sampled with each accepted beat. Each bank keeps a 64-bit written mask, cleared when the bank is freed or on reset.
  - A beat accepted with coef_eob=1 is written normally, then the block completes immediately; the count resets to 0 and the bank is marked full.
  - Row outputs return 0 for unwritten positions.
  - coef_eob on beat 63 behaves exactly as a normal completion.
- Not defined: no coef_eob port and no mask; blocks always complete after exactly 64 beats.

Test Plan:
- Quant table all 1; send coef=n for zigzag index n=0..63 with row_ready=1 -> row 0 = 0,1,5,6,14,15,27,28; row 1 = 2,4,7,13,16,26,29,42; row 7 = 35,36,48,49,57,58,62,63; row_last high only on row 7.
- q[0]=16, all other q=1; block of coef -3 then 63 zeros -> row 0 col 0 = -48; all other outputs 0.
- Extreme values: q[63]=255, beat 63 coef=-32768 -> row 7 col 7 = -8355840; q[0]=255, beat 0 coef=32767 -> row 0 col 0 = 8355585.
- Hold row_ready=0 and stream coef_valid=1 continuously -> coef_ready falls after 128 accepted beats. Assert row_ready for one row at a time -> coef_ready rises exactly one cycle after the row-7 accept of block 0. Data stays stable during every stall.
- Assert rst after 30 beats of a block, then send a fresh 64-beat block -> only the fresh block is output, with correct values, and row_idx starts at 0.
- (JPEG_DQ_EOB_EN) Send 3 beats (5,7,9) with coef_eob on the third -> row 0 = 5,7,0,0,0,0,0,0; row 1 col 0 = 9; all else 0. The next block starts at index 0.
